// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder at the far end of the fetch-address path.
// It accepts a byte address on a valid/ready request channel. It looks up the
// word in an internal word-addressed array. After WAIT_STATES extra cycles it
// returns the instruction on a valid/ready response channel. Out-of-range
// fetches are flagged on rsp_err and return a NOP (32'h0).
//
// Optional feature (compile-time macro):
//   IMEM_MISALIGN_TRAP_EN - when defined, a fetch with address[1:0] != 0 also
//                           sets rsp_err and returns 32'h0. When undefined,
//                           the low address bits are ignored.
//
// Parameters:
//   DEPTH_LOG2  - the array holds 2^DEPTH_LOG2 32-bit words
//   WAIT_STATES - extra cycles between request accept and response (0..15)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   fetch request present
//   req_ready  out  responder can accept a request (IDLE only)
//   req_addr   in   byte fetch address
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts the response
//   rsp_instr  out  fetched instruction word (0 on fault)
//   rsp_addr   out  echo of the accepted request address
//   rsp_err    out  fetch fault
//   wr_en      in   array write strobe (program load), honoured in any state
//   wr_addr    in   word index to write
//   wr_data    in   word to write
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [31:0]           rsp_addr,
    output logic                  rsp_err,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [31:0]           addr_reg;
    logic                  err_reg;
    logic [31:0]           rd_data_reg;
    logic [31:0]           mem [0:DEPTH-1];

    logic                  accept;
    logic                  load;
    logic [31:0]           sel_addr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  fault;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = WAIT_CNT;
                    if (WAIT_CNT == 4'd0) begin
                        state_next = ST_RESP;
                        load       = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_RESP;
                    load       = 1'b1;
                end
            end
            ST_RESP: begin
                // Releasing the response returns to IDLE. No request is taken on this edge.
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch address decode
    // ------------------------------------------------------------------
    // With zero wait states, the array is read on the accept edge itself.
    // The address is therefore taken straight from the request in IDLE.
    // In all other states it is taken from the latched copy.
    always_comb begin
        sel_addr     = (state_reg == ST_IDLE) ? req_addr : addr_reg;
        rd_idx       = sel_addr[DEPTH_LOG2+1:2];
        out_of_range = (sel_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
`ifdef IMEM_MISALIGN_TRAP_EN
        misaligned   = sel_addr[1:0] != 2'b00;
`else
        misaligned   = 1'b0;
`endif
        fault        = out_of_range | misaligned;
    end

    // ------------------------------------------------------------------
    // Control and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= req_addr;
            end
            if (load) begin
                err_reg <= fault;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction array
    // ------------------------------------------------------------------
    // The array is not reset. Writes are accepted in any state, including
    // during reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with read-before-write behaviour. A write to the same
    // index on the load edge is not seen; the old word is returned. Only the
    // output register is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= 32'd0;
        end else if (load) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered values, or decoded from state only
    // ------------------------------------------------------------------
    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_addr  = addr_reg;
    assign rsp_err   = err_reg;
    assign rsp_instr = err_reg ? 32'd0 : rd_data_reg;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Self-checking bench for imem_responder. Two instances share the clock,
// reset and program-load port:
//   u_dut  - DEPTH_LOG2=8, WAIT_STATES=2 (latency, backpressure, faults, reset)
//   u_dut0 - DEPTH_LOG2=8, WAIT_STATES=0 (back-to-back throughput)
//
// Expected responses come from a reference model of the array. They are pushed
// onto a queue when a request is driven, and popped when the response appears.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    localparam int DL = 8;
    localparam int WS = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [DL-1:0] wr_addr;
    logic [31:0] wr_data;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, rsp_instr, rsp_addr;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, rsp_instr0, rsp_addr0;

    logic [31:0] model_mem [0:(1<<DL)-1];
    exp_t        sb_q[$];
    exp_t        sb0_q[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_instr(rsp_instr0),
        .rsp_addr(rsp_addr0), .rsp_err(rsp_err0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of one fetch.
    function automatic exp_t model_rsp(input logic [31:0] a);
        exp_t e;
        logic oor;
        logic mis;
        oor = (a[31:DL+2] != '0);
`ifdef IMEM_MISALIGN_TRAP_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e.addr  = a;
        e.err   = oor | mis;
        e.instr = e.err ? 32'd0 : model_mem[a[DL+1:2]];
        return e;
    endfunction

    task automatic write_word(input logic [DL-1:0] idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_data = d;
        model_mem[idx] = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One fetch on u_dut. The task is entered and left on a negedge.
    // bp      : cycles to hold rsp_ready low once the response is up
    // collide : write the fetched index on the edge that enters RESP
    task automatic do_req(input logic [31:0] a, input int bp, input bit collide);
        exp_t        e;
        int          n;
        int          edges;
        bit          got;
        logic [31:0] new_word;
        new_word = 32'h0BADF00D;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("req_ready_before_req", req_ready, 1'b1);
        rsp_ready = (bp == 0);
        req_valid = 1'b1;
        req_addr  = a;
        sb_q.push_back(model_rsp(a));
        @(posedge clk);                 // accept edge N
        @(negedge clk);
        req_valid = 1'b0;
        // edges = index k of edge N+k that would sample the current outputs
        edges = 1;
        got   = 1'b0;
        while (edges <= 50) begin
            if (collide && edges == WS) begin
                wr_en   = 1'b1;
                wr_addr = a[DL+1:2];
                wr_data = new_word;
            end else begin
                wr_en = 1'b0;
            end
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        wr_en = 1'b0;
        if (collide) begin
            model_mem[a[DL+1:2]] = new_word;
        end
        check("rsp_latency", edges, WS + 1);
        e = sb_q.pop_front();
        if (!got) begin
            return;
        end
        check("rsp_instr", rsp_instr, e.instr);
        check("rsp_addr", rsp_addr, e.addr);
        check("rsp_err", rsp_err, e.err);
        check("req_ready_in_resp", req_ready, 1'b0);
        $display("[TB] fetch addr=%h instr=%h err=%0b latency=%0d", rsp_addr, rsp_instr, rsp_err, edges);
        repeat (bp) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_instr", rsp_instr, e.instr);
            check("bp_addr", rsp_addr, e.addr);
            check("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_valid", rsp_valid, 1'b0);
        check("release_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   saw;
        for (int i = 0; i < (1 << DL); i++) model_mem[i] = 32'd0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = 32'd0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        rsp_ready  = 1'b1;
        req_valid0 = 1'b0;
        req_addr0  = 32'd0;
        rsp_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_rsp_addr", rsp_addr, 32'd0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_req_ready0", req_ready0, 1'b1);
        rst = 1'b0;

        // Program load (shared by both instances)
        write_word(8'd0,   32'h00000020);
        write_word(8'd1,   32'h20010005);
        write_word(8'd2,   32'hAC220008);
        write_word(8'd3,   32'h8C220004);
        write_word(8'd255, 32'hDEADBEEF);

        // Basic fetch, no backpressure
        do_req(32'h0000000C, 0, 1'b0);
        // Backpressure for 5 cycles
        do_req(32'h00000004, 5, 1'b0);
        // Out of range: first word past the array, and the very top of memory
        do_req(32'h00000400, 0, 1'b0);
        do_req(32'hFFFFFFFC, 0, 1'b0);
        // Last valid word
        do_req(32'h000003FC, 0, 1'b0);
        // Misaligned fetch inside word 1
        do_req(32'h00000006, 0, 1'b0);
        // Write on the RESP-entry edge returns the old word; the next fetch sees the new one
        do_req(32'h00000008, 0, 1'b1);
        do_req(32'h00000008, 0, 1'b0);

        // Reset while in WAIT
        req_valid = 1'b1;
        req_addr  = 32'h0000000C;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            if (rsp_valid) saw = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_wait_no_rsp", saw, 1'b0);
        check("rst_wait_req_ready", req_ready, 1'b1);
        check("rst_wait_rsp_addr", rsp_addr, 32'd0);
        check("rst_wait_rsp_instr", rsp_instr, 32'd0);
        check("rst_wait_rsp_err", rsp_err, 1'b0);
        $display("[TB] reset in WAIT: response dropped=%0b", !saw);
        do_req(32'h0000000C, 0, 1'b0);

        // Zero wait states, back-to-back with rsp_ready held high
        rsp_ready0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_req_ready", req_ready0, 1'b1);
            req_valid0 = 1'b1;
            req_addr0  = 32'(i * 4);
            sb0_q.push_back(model_rsp(32'(i * 4)));
            @(posedge clk);             // accept edge
            @(negedge clk);
            e = sb0_q.pop_front();
            check("b2b_rsp_valid", rsp_valid0, 1'b1);
            check("b2b_rsp_instr", rsp_instr0, e.instr);
            check("b2b_rsp_addr", rsp_addr0, e.addr);
            check("b2b_rsp_err", rsp_err0, e.err);
            check("b2b_req_busy", req_ready0, 1'b0);
            $display("[TB] b2b fetch addr=%h instr=%h err=%0b", rsp_addr0, rsp_instr0, rsp_err0);
            @(posedge clk);             // response taken, back to IDLE
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        check("b2b_final_valid", rsp_valid0, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
